rda_seq_ctrl: RTL and testbench
===============================

Name: rda_seq_ctrl

Overview:
- Multi-cycle sequencer for the recursive-doubling (kill/propagate/generate) adder in the ALU.
- Holds one WIDTH+1-entry KPG vector in a register and applies one doubling combine stage per clock (distances 1, 2, 4, ...) until every entry resolves to kill or generate.
- Then forms sum, carry-out and signed overflow.
- Sits between the ALU operand latch and the result writeback; uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand width in bits.
- NSTEPS, $clog2(WIDTH+1), number of doubling steps (4 for WIDTH=8); derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when op_sub=1.
- op_sub  in  1  1 = A - B (B inverted, carry-in forced 1).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry-out (for subtract: 1 = no borrow).
- ovf  out  1  registered two's-complement overflow.
- busy  out  1  high in STEP or DONE.

Behaviour:
- Reset, applied on any clock edge with rst=1 and in any state:
  - state=IDLE, step counter=0, KPG register=all kill (00).
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
  - An operation in flight is discarded with no output.
- KPG encoding:
  - 00 kill; 01 or 10 propagate; 11 generate.
  - Combine(hi, lo): hi if hi is kill or generate; otherwise lo.
- States: IDLE, STEP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch a and b_eff, where b_eff = op_sub ? ~b : b, and c0 = op_sub ? 1 : cin.
  - Load KPG entry 0 = {c0,c0} and entry i = {a[i-1], b_eff[i-1]} for i=1..WIDTH.
  - Set step counter to 0; go to STEP.
- STEP:
  - Each edge applies one doubling with distance d = 2^step: entry i = Combine(entry i, entry i-d) for i >= d; entries i < d unchanged.
  - Counter increments each edge.
  - On the edge that applies step NSTEPS-1, also register the outputs:
    - carry into bit i = resolved entry i bit 1.
    - sum[i] = a[i] ^ b_eff[i] ^ carry_i.
    - cout = entry WIDTH bit 1.
    - ovf = carry into MSB ^ cout.
  - Same edge: go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf held stable.
  - On out_ready=1, go to IDLE and deassert out_valid the next cycle.
  - in_valid is ignored until back in IDLE.
- Latency: out_valid rises NSTEPS edges after the accepting edge (4 for WIDTH=8). Throughput is one result per NSTEPS+2 cycles minimum with out_ready held high.
- in_valid or operand changes while busy: no effect on the latched operands.
- sum, cout and ovf keep their last values after DONE until the next completion or reset.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package rda_pkg holds:
  - KPG constants KPG_KILL=2'b00, KPG_GEN=2'b11.
  - State enum {IDLE, STEP, DONE}.
  - Function kpg_combine(hi, lo).
- One sub-module: rda_kpg_stage, a combinational single doubling stage over WIDTH+1 entries with a runtime distance select (1/2/4/8), instantiated once and reused every STEP cycle.
- The FSM, counter and output registers live in rda_seq_ctrl.

Test Plan:
- a=0x5A, b=0x3C, cin=0, op_sub=0 -> after 4 edges sum=0x96, cout=0, ovf=1; out_valid held with out_ready=1 for exactly one cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Subtract: a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> sum, cout, ovf stable, in_ready=0; release -> IDLE next cycle; a new request completes correctly.
- Reset mid-operation: assert rst for 1 cycle at step 2 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; a following request 0x01+0x01 -> sum=0x02.
- Random: 1000 random (a, b, cin, op_sub) with random out_ready stalls -> each result matches a reference model and latency is exactly 4 edges.

Source files
------------

// File: rtl/rda_pkg.sv
// Shared definitions for the recursive-doubling adder sequencer.
//   KPG_KILL / KPG_GEN : resolved kill / generate codes (01, 10 = propagate)
//   state_e            : sequencer states IDLE, STEP, DONE
//   kpg_combine        : one prefix combine of a higher entry with a lower one
package rda_pkg;

  localparam logic [1:0] KPG_KILL = 2'b00;
  localparam logic [1:0] KPG_GEN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  // A resolved entry (kill or generate) dominates; a propagate entry
  // inherits whatever the lower entry says.
  function automatic logic [1:0] kpg_combine(input logic [1:0] hi,
                                             input logic [1:0] lo);
    return ((hi == KPG_KILL) || (hi == KPG_GEN)) ? hi : lo;
  endfunction

endpackage

// File: rtl/rda_seq_ctrl_if.sv
// Operand / result handshake bundle for rda_seq_ctrl.
//   in_valid/in_ready   : operand request handshake (a, b, cin, op_sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   busy                : sequencer is in STEP or DONE
// master = operand producer / result consumer, slave = the sequencer.
interface rda_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/rda_kpg_stage.sv
// One combinational recursive-doubling stage over WIDTH+1 KPG entries.
//   kpg_i      : current KPG vector (entry 0 = carry-in)
//   dist_sel_i : step index s, combine distance d = 2**s
//   kpg_o      : entry i = combine(entry i, entry i-d) for i >= d, else unchanged
module rda_kpg_stage
  import rda_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NSTEPS = 4,
  parameter int SEL_W  = 2
) (
  input  logic [WIDTH:0][1:0] kpg_i,
  input  logic [SEL_W-1:0]    dist_sel_i,
  output logic [WIDTH:0][1:0] kpg_o
);

  // Every distance is precomputed per entry; the runtime select picks one.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_ent
    logic [1:0] cand [NSTEPS];
    for (genvar s = 0; s < NSTEPS; s++) begin : g_dist
      if (i >= (1 << s)) begin : g_comb
        assign cand[s] = kpg_combine(kpg_i[i], kpg_i[i-(1<<s)]);
      end else begin : g_pass
        assign cand[s] = kpg_i[i];
      end
    end
    assign kpg_o[i] = cand[dist_sel_i];
  end

endmodule

// File: rtl/rda_seq_ctrl.sv
// Multi-cycle recursive-doubling adder sequencer.
// Latches one operand pair, runs NSTEPS doubling stages (one per clock) on a
// registered KPG vector, then registers sum, carry-out and signed overflow.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rda_seq_ctrl_if slave (operand and result handshakes, busy)
module rda_seq_ctrl
  import rda_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  rda_seq_ctrl_if.slave bus
);

  localparam int NSTEPS = $clog2(WIDTH + 1);
  localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WIDTH:0][1:0] kpg_q, kpg_d;
  logic [WIDTH:0][1:0] stage_kpg;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    beff_q;

  logic [WIDTH-1:0]    b_in_eff;
  logic                c0;
  logic                ld;
  logic                last_step;

  // Subtraction is A + ~B + 1.
  assign b_in_eff  = bus.op_sub ? ~bus.b : bus.b;
  assign c0        = bus.op_sub | bus.cin;
  assign ld        = (state_q == IDLE) && bus.in_valid;
  assign last_step = (step_q == STEP_W'(NSTEPS - 1));

  rda_kpg_stage #(
    .WIDTH  (WIDTH),
    .NSTEPS (NSTEPS),
    .SEL_W  (STEP_W)
  ) u_stage (
    .kpg_i      (kpg_q),
    .dist_sel_i (step_q),
    .kpg_o      (stage_kpg)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    kpg_d   = kpg_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = STEP;
          step_d   = '0;
          kpg_d[0] = {c0, c0};
          for (int i = 0; i < WIDTH; i++) begin
            kpg_d[i+1] = {bus.a[i], b_in_eff[i]};
          end
        end
      end
      STEP: begin
        kpg_d  = stage_kpg;
        step_d = step_q + 1'b1;
        if (last_step) begin
          state_d = DONE;
          // After the final stage every entry is resolved: entry i bit 1 is
          // the carry into bit i, entry WIDTH bit 1 is the carry-out.
          for (int i = 0; i < WIDTH; i++) begin
            sum_d[i] = a_q[i] ^ beff_q[i] ^ stage_kpg[i][1];
          end
          cout_d = stage_kpg[WIDTH][1];
          ovf_d  = stage_kpg[WIDTH-1][1] ^ stage_kpg[WIDTH][1];
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      kpg_q   <= '{default: KPG_KILL};
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      kpg_q   <= kpg_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand copies only feed the final sum XOR; they need no reset.
  always_ff @(posedge clk) begin
    if (ld) begin
      a_q    <= bus.a;
      beff_q <= b_in_eff;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rda_seq_ctrl.sv
module tb_rda_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int LAT   = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rda_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  rda_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition of A, effective B and carry-in.
  function automatic logic [9:0] ref_add(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mc, input logic ms);
    logic [7:0] be;
    logic [8:0] full;
    logic       c;
    logic       ov;
    be   = ms ? ~mb : mb;
    c    = ms ? 1'b1 : mc;
    full = {1'b0, ma} + {1'b0, be} + {8'd0, c};
    ov   = (ma[7] == be[7]) && (full[7] != ma[7]);
    return {ov, full[8], full[7:0]};
  endfunction

  task automatic junk_inputs();
    bus.in_valid = 1'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.cin      = 1'($urandom);
    bus.op_sub   = 1'($urandom);
  endtask

  // Runs one operation from an IDLE negedge. stall = cycles out_ready held low in DONE.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic ts, input int stall,
                       output logic [7:0] o_sum, output logic o_cout, output logic o_ovf);
    logic [9:0] exp;
    int         lat;
    int         w;
    exp = ref_add(ta, tb_v, tc, ts);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = ta;
    bus.b         = tb_v;
    bus.cin       = tc;
    bus.op_sub    = ts;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      junk_inputs();
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("sum", 32'(bus.sum), 32'(exp[7:0]));
    chk("cout", 32'(bus.cout), 32'(exp[8]));
    chk("ovf", 32'(bus.ovf), 32'(exp[9]));
    o_sum  = bus.sum;
    o_cout = bus.cout;
    o_ovf  = bus.ovf;
    bus.out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      junk_inputs();
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_sum", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    chk("held_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp));
  endtask

  initial begin
    logic [7:0] s;
    logic       co;
    logic       ov;
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, s, co, ov);
    chk("dir_5A_3C", 32'({ov, co, s}), 32'({1'b1, 1'b0, 8'h96}));
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, s, co, ov);
    chk("dir_FF_01", 32'({ov, co, s}), 32'({1'b0, 1'b1, 8'h00}));
    do_op(8'h7F, 8'h00, 1'b1, 1'b0, 1, s, co, ov);
    chk("dir_7F_00_c1", 32'({ov, co, s}), 32'({1'b1, 1'b0, 8'h80}));
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 0, s, co, ov);
    chk("dir_sub_10_20", 32'({ov, co, s}), 32'({1'b0, 1'b0, 8'hF0}));
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 5, s, co, ov);
    chk("dir_sub_80_01", 32'({ov, co, s}), 32'({1'b1, 1'b1, 8'h7F}));
    do_op(8'h33, 8'h44, 1'b1, 1'b0, 2, s, co, ov);
    chk("dir_after_bp", 32'({ov, co, s}), 32'({1'b0, 1'b0, 8'h78}));

    // Reset during step 2 discards the operation.
    bus.in_valid = 1'b1;
    bus.a        = 8'hC3;
    bus.b        = 8'h5A;
    bus.cin      = 1'b1;
    bus.op_sub   = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
    repeat (LAT + 1) @(negedge clk);
    chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, s, co, ov);
    chk("dir_01_01", 32'(s), 32'h02);

    for (int n = 0; n < 1000; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), s, co, ov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
